// File: rtl/tcdm_mux_pkg.sv
// rtl/tcdm_mux_pkg.sv - shared types and sizing helpers for the credit-limited TCDM mux
package tcdm_mux_pkg;

    typedef enum logic {
        ARB_RR,
        ARB_FIXED
    } arb_mode_e;

    // Bits needed to index n values; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcdm_lock_arb.sv
// rtl/tcdm_lock_arb.sv - round-robin / fixed-priority arbiter that holds its grant until accepted
module tcdm_lock_arb
    import tcdm_mux_pkg::*;
#(
    parameter int        NrPorts = 2,
    parameter arb_mode_e ArbMode = ARB_RR,
    localparam int       SelW    = idx_width(NrPorts)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NrPorts-1:0] eligible,
    input  logic               ready,
    output logic [SelW-1:0]    sel,
    output logic               valid
);

    logic [SelW-1:0] rr_ptr;
    logic [SelW-1:0] lock_sel;
    logic            locked;
    logic [SelW-1:0] pick;
    logic            pick_valid;
    int              idx;

    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        idx        = 0;
        for (int k = 0; k < NrPorts; k++) begin
            idx = (ArbMode == ARB_RR) ? int'(rr_ptr) + k : k;
            if (idx >= NrPorts) begin
                idx = idx - NrPorts;
            end
            if (!pick_valid && eligible[idx]) begin
                pick       = SelW'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    // A stalled grant stays put; it is only released if its requester stops being eligible.
    always_comb begin
        if (locked && eligible[lock_sel]) begin
            sel   = lock_sel;
            valid = 1'b1;
        end else begin
            sel   = pick;
            valid = pick_valid;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            lock_sel <= '0;
            locked   <= 1'b0;
        end else begin
            locked   <= valid & ~ready;
            lock_sel <= sel;
            if (ArbMode == ARB_RR && valid && ready) begin
                rr_ptr <= (sel == SelW'(NrPorts - 1)) ? '0 : sel + SelW'(1);
            end
        end
    end

endmodule

// File: rtl/tcdm_mux_credit.sv
// rtl/tcdm_mux_credit.sv - N-to-1 TCDM mux with per-port credits and in-order response steering
module tcdm_mux_credit
    import tcdm_mux_pkg::*;
#(
    parameter int        NrPorts        = 2,
    parameter int        AddrWidth      = 32,
    parameter int        DataWidth      = 32,
    parameter type       user_t         = logic,
    parameter int        RespDepth      = 8,
    parameter int        MaxOutstanding = 4,
    parameter arb_mode_e ArbMode        = ARB_RR,
    localparam int       QWidth         = AddrWidth + 1 + DataWidth + DataWidth / 8 + $bits(user_t),
    localparam int       RspWidth       = DataWidth + 2,
    localparam int       OutWidth       = idx_width(RespDepth + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    // request word {q, q_valid}; q is opaque {addr, write, data, strb, user}
    input  logic [NrPorts-1:0][QWidth:0]       slv_req_i,
    // response word {p.data, p_valid, q_ready}
    output logic [NrPorts-1:0][RspWidth-1:0]   slv_rsp_o,
    output logic [QWidth:0]                    mst_req_o,
    input  logic [RspWidth-1:0]                mst_rsp_i,
    output logic [OutWidth-1:0]                outstanding_o,
    output logic                               rsp_err_o
);

    localparam int SelW = idx_width(NrPorts);
    localparam int PtrW = idx_width(RespDepth);
    localparam int CntW = idx_width(MaxOutstanding + 1);

    logic [SelW-1:0]      sel;
    logic [SelW-1:0]      head_sel;
    logic                 arb_valid;
    logic                 q_valid;
    logic                 q_ready;
    logic                 p_valid;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [DataWidth-1:0] rsp_data;
    logic [NrPorts-1:0]   eligible;
    logic [NrPorts-1:0]   cnt_inc;
    logic [NrPorts-1:0]   cnt_dec;
    logic [CntW-1:0]      cnt [NrPorts];
    logic [SelW-1:0]      idx_fifo [RespDepth];
    logic [PtrW-1:0]      head;
    logic [PtrW-1:0]      tail;
    logic [OutWidth-1:0]  occ;
    logic                 err;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(RespDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign q_ready  = mst_rsp_i[0];
    assign p_valid  = mst_rsp_i[1];
    assign rsp_data = mst_rsp_i[RspWidth-1:2];
    assign full     = (occ == OutWidth'(RespDepth));
    assign empty    = (occ == '0);

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NrPorts; i++) begin
            eligible[i] = slv_req_i[i][0] & (cnt[i] < CntW'(MaxOutstanding)) & ~full;
        end
    end

    tcdm_lock_arb #(
        .NrPorts (NrPorts),
        .ArbMode (ArbMode)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .eligible (eligible),
        .ready    (q_ready),
        .sel      (sel),
        .valid    (arb_valid)
    );

    assign q_valid   = arb_valid & ~rst_i;
    assign push      = q_valid & q_ready;
    assign head_sel  = idx_fifo[head];
    assign pop       = p_valid & ~empty & ~rst_i;
    assign mst_req_o = {slv_req_i[sel][QWidth:1], q_valid};

    // q_ready is only shown to the granted port while it is actually being offered.
    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int i = 0; i < NrPorts; i++) begin
            cnt_inc[i]   = push && (sel == SelW'(i));
            cnt_dec[i]   = pop && (head_sel == SelW'(i));
            slv_rsp_o[i] = {rsp_data, cnt_dec[i], cnt_inc[i]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            idx_fifo[tail] <= sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            err  <= 1'b0;
            for (int i = 0; i < NrPorts; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (push) begin
                tail <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OutWidth'(1);
                2'b01:   occ <= occ - OutWidth'(1);
                default: occ <= occ;
            endcase
            for (int i = 0; i < NrPorts; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    cnt[i] <= cnt[i] + CntW'(1);
                end else if (cnt_dec[i] && !cnt_inc[i]) begin
                    cnt[i] <= cnt[i] - CntW'(1);
                end
            end
            if (p_valid && empty) begin
                err <= 1'b1;
            end
        end
    end

    assign outstanding_o = occ;
    assign rsp_err_o     = err;

    for (genvar g = 0; g < NrPorts; g++) begin : g_cnt_chk
        a_cnt_ovf: assert property (@(posedge clk_i) disable iff (rst_i)
            (cnt_inc[g] && !cnt_dec[g]) |-> (cnt[g] < CntW'(MaxOutstanding)));
        a_cnt_unf: assert property (@(posedge clk_i) disable iff (rst_i)
            (cnt_dec[g] && !cnt_inc[g]) |-> (cnt[g] != '0));
    end

    a_occ_range: assert property (@(posedge clk_i) disable iff (rst_i)
        occ <= OutWidth'(RespDepth));

endmodule

// File: tb/tb_tcdm_mux_credit.sv
// tb/tb_tcdm_mux_credit.sv - directed vector bench for tcdm_mux_credit (RR and fixed instances)
module tb_tcdm_mux_credit;
    import tcdm_mux_pkg::*;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int QW = AW + 1 + DW + DW / 8 + 1;
    localparam int RW = DW + 2;
    localparam int OW = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NP-1:0]          vld;
    logic                   qrdy;
    logic                   pv;
    logic [DW-1:0]          pdata;
    logic [NP-1:0][QW:0]    slv_req;
    logic [RW-1:0]          mst_rsp;

    logic [NP-1:0][RW-1:0]  rr_rsp, fx_rsp;
    logic [QW:0]            rr_mreq, fx_mreq;
    logic [OW-1:0]          rr_out, fx_out;
    logic                   rr_err, fx_err;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [QW-1:0] qpat(input int i);
        return {32'hA000_0000 + 32'(i), 1'b1, 32'h5A5A_0000 + 32'(i), 4'hF, 1'b0};
    endfunction

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            slv_req[i] = {qpat(i), vld[i]};
        end
    end
    assign mst_rsp = {pdata, pv, qrdy};

    tcdm_mux_credit #(
        .NrPorts(NP), .AddrWidth(AW), .DataWidth(DW), .user_t(logic),
        .RespDepth(4), .MaxOutstanding(2), .ArbMode(ARB_RR)
    ) u_rr (
        .clk_i(clk), .rst_i(rst), .slv_req_i(slv_req), .slv_rsp_o(rr_rsp),
        .mst_req_o(rr_mreq), .mst_rsp_i(mst_rsp), .outstanding_o(rr_out), .rsp_err_o(rr_err)
    );

    tcdm_mux_credit #(
        .NrPorts(NP), .AddrWidth(AW), .DataWidth(DW), .user_t(logic),
        .RespDepth(4), .MaxOutstanding(2), .ArbMode(ARB_FIXED)
    ) u_fx (
        .clk_i(clk), .rst_i(rst), .slv_req_i(slv_req), .slv_rsp_o(fx_rsp),
        .mst_req_o(fx_mreq), .mst_rsp_i(mst_rsp), .outstanding_o(fx_out), .rsp_err_o(fx_err)
    );

    function automatic logic [NP-1:0] qr_of(input logic [NP-1:0][RW-1:0] r);
        logic [NP-1:0] v;
        for (int i = 0; i < NP; i++) v[i] = r[i][0];
        return v;
    endfunction

    function automatic logic [NP-1:0] pv_of(input logic [NP-1:0][RW-1:0] r);
        logic [NP-1:0] v;
        for (int i = 0; i < NP; i++) v[i] = r[i][1];
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [NP-1:0] v, input logic qr,
                         input logic p, input logic [DW-1:0] d);
        rst   = r;
        vld   = v;
        qrdy  = qr;
        pv    = p;
        pdata = d;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          rst;
        logic [NP-1:0] vld;
        logic          qrdy;
        logic          pv;
        logic          mv;
        int            sel;
        logic [NP-1:0] qr;
        logic [NP-1:0] pvo;
        logic [OW-1:0] outs;
        logic          err;
    } vec_t;

    vec_t tbl [16];

    initial begin
        // rst vld qrdy pv | mst_valid sel q_ready p_valid outstanding err
        tbl[0]  = '{1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 0, 3'b000, 3'b000, 3'd0, 1'b0};
        tbl[1]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 0, 3'b001, 3'b000, 3'd0, 1'b0};
        tbl[2]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 1, 3'b010, 3'b000, 3'd1, 1'b0};
        tbl[3]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 2, 3'b100, 3'b000, 3'd2, 1'b0};
        tbl[4]  = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 0, 3'b000, 3'b000, 3'd3, 1'b0};
        tbl[5]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 0, 3'b001, 3'b000, 3'd3, 1'b0};
        tbl[6]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 0, 3'b000, 3'b000, 3'd4, 1'b0};
        tbl[7]  = '{1'b0, 3'b111, 1'b1, 1'b1, 1'b0, 0, 3'b000, 3'b001, 3'd4, 1'b0};
        tbl[8]  = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 1, 3'b000, 3'b000, 3'd3, 1'b0};
        tbl[9]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 0, 3'b000, 3'b010, 3'd3, 1'b0};
        tbl[10] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 0, 3'b000, 3'b100, 3'd2, 1'b0};
        tbl[11] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 0, 3'b000, 3'b001, 3'd1, 1'b0};
        tbl[12] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 0, 3'b000, 3'b000, 3'd0, 1'b0};
        tbl[13] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 0, 3'b000, 3'b000, 3'd0, 1'b1};
        tbl[14] = '{1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 0, 3'b000, 3'b000, 3'd0, 1'b1};
        tbl[15] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 0, 3'b000, 3'b000, 3'd0, 1'b0};

        rst = 1'b1; vld = '0; qrdy = 1'b0; pv = 1'b0; pdata = '0;
        repeat (2) tick();

        // round-robin instance: grants, full FIFO, push+pop at full, spurious response, reset
        for (int k = 0; k < 16; k++) begin
            drive(tbl[k].rst, tbl[k].vld, tbl[k].qrdy, tbl[k].pv, 32'hD000_0000 + 32'(k));
            chk($sformatf("v%0d mst_valid", k), 128'(rr_mreq[0]), 128'(tbl[k].mv));
            if (tbl[k].mv)
                chk($sformatf("v%0d payload", k), 128'(rr_mreq[QW:1]), 128'(qpat(tbl[k].sel)));
            chk($sformatf("v%0d q_ready", k), 128'(qr_of(rr_rsp)), 128'(tbl[k].qr));
            chk($sformatf("v%0d p_valid", k), 128'(pv_of(rr_rsp)), 128'(tbl[k].pvo));
            chk($sformatf("v%0d p_data", k), 128'(rr_rsp[k % NP][RW-1:2]), 128'(32'hD000_0000 + 32'(k)));
            chk($sformatf("v%0d outstanding", k), 128'(rr_out), 128'(tbl[k].outs));
            chk($sformatf("v%0d rsp_err", k), 128'(rr_err), 128'(tbl[k].err));
            tick();
        end

        // lock-in on the fixed-priority instance
        drive(1'b1, 3'b000, 1'b0, 1'b0, '0); tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 3'b010, 1'b0, 1'b0, '0);
            chk("lock valid", 128'(fx_mreq[0]), 128'(1'b1));
            chk("lock payload p1", 128'(fx_mreq[QW:1]), 128'(qpat(1)));
            tick();
        end
        drive(1'b0, 3'b011, 1'b0, 1'b0, '0);
        chk("lock hold vs p0", 128'(fx_mreq[QW:1]), 128'(qpat(1)));
        tick();
        drive(1'b0, 3'b011, 1'b1, 1'b0, '0);
        chk("lock accept payload", 128'(fx_mreq[QW:1]), 128'(qpat(1)));
        chk("lock accept q_ready", 128'(qr_of(fx_rsp)), 128'(3'b010));
        tick();
        drive(1'b0, 3'b011, 1'b1, 1'b0, '0);
        chk("after lock p0 payload", 128'(fx_mreq[QW:1]), 128'(qpat(0)));
        chk("after lock p0 q_ready", 128'(qr_of(fx_rsp)), 128'(3'b001));
        tick();

        // credit limit of 2 per port on the fixed-priority instance
        drive(1'b1, 3'b000, 1'b0, 1'b0, '0); tick();
        drive(1'b0, 3'b011, 1'b1, 1'b0, '0);
        chk("credit g1", 128'(qr_of(fx_rsp)), 128'(3'b001));
        tick();
        drive(1'b0, 3'b011, 1'b1, 1'b0, '0);
        chk("credit g2", 128'(qr_of(fx_rsp)), 128'(3'b001));
        tick();
        drive(1'b0, 3'b011, 1'b1, 1'b0, '0);
        chk("credit p1 served", 128'(qr_of(fx_rsp)), 128'(3'b010));
        tick();
        drive(1'b0, 3'b001, 1'b0, 1'b1, 32'h1111_2222);
        chk("credit outstanding", 128'(fx_out), 128'(3'd3));
        chk("credit p0 blocked", 128'(fx_mreq[0]), 128'(1'b0));
        chk("credit resp to p0", 128'(pv_of(fx_rsp)), 128'(3'b001));
        tick();
        drive(1'b0, 3'b001, 1'b1, 1'b0, '0);
        chk("credit p0 re-enabled", 128'(qr_of(fx_rsp)), 128'(3'b001));
        tick();

        // response ordering 2,0,2 on the round-robin instance
        drive(1'b1, 3'b000, 1'b0, 1'b0, '0); tick();
        drive(1'b0, 3'b100, 1'b1, 1'b0, '0);
        chk("order g2", 128'(qr_of(rr_rsp)), 128'(3'b100)); tick();
        drive(1'b0, 3'b001, 1'b1, 1'b0, '0);
        chk("order g0", 128'(qr_of(rr_rsp)), 128'(3'b001)); tick();
        drive(1'b0, 3'b100, 1'b1, 1'b0, '0);
        chk("order g2b", 128'(qr_of(rr_rsp)), 128'(3'b100)); tick();
        drive(1'b0, 3'b000, 1'b0, 1'b1, 32'hAAAA_0001);
        chk("order rA port", 128'(pv_of(rr_rsp)), 128'(3'b100));
        chk("order rA data", 128'(rr_rsp[2][RW-1:2]), 128'(32'hAAAA_0001)); tick();
        drive(1'b0, 3'b000, 1'b0, 1'b1, 32'hBBBB_0002);
        chk("order rB port", 128'(pv_of(rr_rsp)), 128'(3'b001));
        chk("order rB data", 128'(rr_rsp[0][RW-1:2]), 128'(32'hBBBB_0002)); tick();
        drive(1'b0, 3'b000, 1'b0, 1'b1, 32'hCCCC_0003);
        chk("order rC port", 128'(pv_of(rr_rsp)), 128'(3'b100));
        chk("order rC data", 128'(rr_rsp[2][RW-1:2]), 128'(32'hCCCC_0003)); tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, '0);
        chk("order drained", 128'(rr_out), 128'(3'd0)); tick();

        // sticky error, then reset with 3 outstanding and a late response
        drive(1'b1, 3'b000, 1'b0, 1'b0, '0); tick();
        drive(1'b0, 3'b000, 1'b0, 1'b1, 32'h0BAD_0000);
        chk("spurious no p_valid", 128'(pv_of(rr_rsp)), 128'(3'b000)); tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, '0);
        chk("spurious err set", 128'(rr_err), 128'(1'b1)); tick();
        repeat (3) begin
            drive(1'b0, 3'b111, 1'b1, 1'b0, '0); tick();
        end
        drive(1'b0, 3'b000, 1'b0, 1'b0, '0);
        chk("pre-reset outstanding", 128'(rr_out), 128'(3'd3));
        chk("pre-reset err sticky", 128'(rr_err), 128'(1'b1)); tick();
        drive(1'b1, 3'b111, 1'b1, 1'b0, '0);
        chk("in-reset q_valid", 128'(rr_mreq[0]), 128'(1'b0)); tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, '0);
        chk("post-reset outstanding", 128'(rr_out), 128'(3'd0));
        chk("post-reset err", 128'(rr_err), 128'(1'b0)); tick();
        drive(1'b0, 3'b000, 1'b0, 1'b1, 32'h0000_BEEF);
        chk("late resp dropped", 128'(pv_of(rr_rsp)), 128'(3'b000)); tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, '0);
        chk("late resp err", 128'(rr_err), 128'(1'b1)); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tcdm_mux_credit.md
Name: tcdm_mux_credit

Overview:
Multiplexes NrPorts TCDM request/response ports onto one master TCDM port. It has a selectable arbitration mode and a per-port outstanding-transaction credit limit. An index FIFO steers in-order responses back to the originating port, and a sticky error flags unexpected responses. It sits between core/accelerator TCDM masters and a single interconnect or bank port, and succeeds the plain round-robin mux.

Parameters:
NrPorts, 2, number of slave ports; 1 is legal, with credit tracking still active.
AddrWidth, 32, TCDM address width.
DataWidth, 32, TCDM data width; strobe width is DataWidth/8.
user_t, logic, user field type.
RespDepth, 8, index FIFO depth and maximum total outstanding requests; must be at least 1.
MaxOutstanding, 4, maximum outstanding requests per port; must be between 1 and RespDepth.
ArbMode, ARB_RR, ARB_RR (round-robin) or ARB_FIXED (lowest index wins).
tcdm_req_t, logic, request struct {q, q_valid}.
tcdm_rsp_t, logic, response struct {p.data, p_valid, q_ready}.

Ports:
clk_i  in  1  clock, all state on rising edge.
rst_i  in  1  synchronous active-high reset.
slv_req_i  in  NrPorts x tcdm_req_t  slave requests.
slv_rsp_o  out  NrPorts x tcdm_rsp_t  slave responses.
mst_req_o  out  tcdm_req_t  master request.
mst_rsp_i  in  tcdm_rsp_t  master response.
outstanding_o  out  idx_width(RespDepth+1)  total outstanding count.
rsp_err_o  out  1  sticky: p_valid arrived while the FIFO was empty.

Behaviour:
- Eligibility: port i is eligible when slv_req_i[i].q_valid = 1, cnt[i] < MaxOutstanding, and the FIFO is not full.
- Request path is combinational with zero latency:
  - mst_req_o.q is the q field of the selected port.
  - mst_req_o.q_valid = 1 when any port is eligible.
  - slv_rsp_o[i].q_ready = (i == sel) & mst_rsp_i.q_ready.
- Lock-in: once q_valid is presented and not accepted, sel and the payload hold until the handshake.
  - This is safe because eligibility of the locked port can only be lost by a push, which has not yet happened for it.
- ARB_RR: search starts at pointer rr_ptr. On handshake, rr_ptr <= sel+1, wrapping to 0 after NrPorts-1.
- ARB_FIXED: the lowest eligible index wins, except that lock-in still applies.
- Push (q_valid & q_ready): write sel to the FIFO tail and increment cnt[sel].
- Response path is combinational with zero latency, in order:
  - slv_rsp_o[i].p.data = mst_rsp_i.p.data for all i.
  - slv_rsp_o[i].p_valid = mst_rsp_i.p_valid & FIFO non-empty & (head == i).
- Pop (p_valid with FIFO non-empty): advance the head and decrement cnt[head].
- Simultaneous push and pop:
  - FIFO occupancy is unchanged.
  - If the push and pop target the same port, that cnt is unchanged.
  - A full FIFO blocks the push even when a pop occurs in the same cycle; no fall-through.
- p_valid with an empty FIFO: the response is dropped, no slave p_valid is asserted, and rsp_err_o <= 1.
  - rsp_err_o clears only on reset.
- outstanding_o equals the FIFO occupancy, which also equals the sum of cnt[].
- Reset (rst_i = 1 at a clock edge):
  - FIFO is emptied, all cnt = 0, rr_ptr = 0, lock is cleared, rsp_err_o = 0, outstanding_o = 0.
  - While rst_i is high, mst_req_o.q_valid and all slv_rsp_o q_ready/p_valid are forced to 0.
  - Reset mid-transaction discards in-flight tracking; later responses raise rsp_err_o.
- Counter widths: cnt is idx_width(MaxOutstanding+1) bits; the FIFO pointer wraps at RespDepth.
  - Overflow and underflow are impossible by construction; assertions check both.

Decomposition:
- tcdm_mux_pkg: arb_mode_e {ARB_RR, ARB_FIXED} and a helper function for cnt width.
- Sub-module tcdm_lock_arb: NrPorts request/eligible vector in, sel/valid out, implementing the RR pointer, fixed mode and lock-in.
- The index FIFO and per-port counters stay in the top level.

Test Plan:
- Three ports with ARB_RR, all q_valid held high, q_ready always 1:
  - Grants follow 0,1,2,0,… one per cycle.
  - After 3 pushes with no responses, outstanding_o = 3.
- Lock-in with ARB_FIXED:
  - Port 1 valid, q_ready = 0 for 3 cycles, then port 0 asserts valid.
  - sel stays 1 and the payload is stable until q_ready = 1; port 0 is granted the next cycle.
- Credit limit with MaxOutstanding = 2 and no responses:
  - Port 0 gets 2 grants, then becomes ineligible and port 1 is served.
  - One p_valid re-enables port 0.
- FIFO full with RespDepth = 4 and 4 outstanding:
  - q_valid = 0 even though ports are requesting.
  - Push and pop in the same cycle at full: the push is blocked and occupancy drops to 3.
- Response ordering:
  - Grants in the order 2,0,2; responses with data A, B, C.
  - p_valid appears on ports 2, 0, 2 in that order, with data A, B, C.
- Spurious response and reset:
  - p_valid with an empty FIFO sets rsp_err_o = 1 and asserts no slave p_valid.
  - Reset with 3 outstanding: outstanding_o = 0 and rsp_err_o = 0 on the next cycle.
